joyencoder_neptuno: RTL and testbench

//  Serial joystick transmitter: the device side of the NeptUNO two-player joystick link.

---
 rtl/joy_neptuno_pkg.sv | 23 ++
 rtl/joy_sync_edge.sv | 31 +++
 rtl/joyencoder_neptuno.sv | 106 ++++++++++
 tb/tb_joyencoder_neptuno.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/joy_neptuno_pkg.sv
// Shared definitions for the NeptUNO two-player joystick link (encoder and decoder sides).
// Button bit positions, idle pattern, frame length and the serial frame packing order.
package joy_neptuno_pkg;

    localparam int JOY_UP     = 0;
    localparam int JOY_DOWN   = 1;
    localparam int JOY_LEFT   = 2;
    localparam int JOY_RIGHT  = 3;
    localparam int JOY_FIRE1  = 4;
    localparam int JOY_FIRE2  = 5;
    localparam int JOY_FIRE3  = 6;
    localparam int JOY_START  = 7;

    localparam logic [7:0] JOY_IDLE   = 8'hFF;
    localparam int         FRAME_BITS = 16;

    // Player 1 occupies the upper byte so that its start bit leaves the link first.
    function automatic logic [FRAME_BITS-1:0] joy_pack(input logic [7:0] p1,
                                                       input logic [7:0] p2);
        return {p1, p2};
    endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// Multi-stage synchronizer for an idle-high asynchronous input, with level and
// single-cycle rise/fall pulses derived from the synchronized level.
module joy_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/joyencoder_neptuno.sv
// Device side of the NeptUNO joystick link: emulates two chained 74HC165 shift registers,
// plus shift counting, end-of-frame pulse and a host-activity watchdog.
module joyencoder_neptuno
    import joy_neptuno_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       joy_clk_i,
    input  logic       joy_load_i,
    output logic       joy_data_o,
    input  logic [7:0] joy1_i,
    input  logic [7:0] joy2_i,
    output logic [4:0] shift_count_o,
    output logic       frame_o,
    output logic       link_active_o
);

    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [4:0]      CNT_MAX = 5'(FRAME_BITS);

    logic clk_rise;
    logic load_n;
    logic load_fall;
    logic clk_level_unused;
    logic clk_fall_unused;
    logic load_rise_unused;

    joy_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (joy_clk_i),
        .level_o (clk_level_unused),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall_unused)
    );

    joy_sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (joy_load_i),
        .level_o (load_n),
        .rise_o  (load_rise_unused),
        .fall_o  (load_fall)
    );

    logic [FRAME_BITS-1:0] shreg_q;
    logic [4:0]            count_q;
    logic                  frame_q;
    logic                  load_q;
    logic [TW-1:0]         tmo_q;
    logic [TW-1:0]         tmo_d;
    logic                  link_q;

    always_comb begin
        tmo_d = tmo_q;
        if (load_fall) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Deciding on the delayed load level means a clock rise that coincides with
    // LOAD's release is swallowed, so the host first sees player 1 start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '1;
            count_q <= '0;
            frame_q <= 1'b0;
            load_q  <= 1'b1;
            tmo_q   <= '0;
            link_q  <= 1'b0;
        end else begin
            load_q  <= load_n;
            frame_q <= 1'b0;
            if (!load_q) begin
                shreg_q <= joy_pack(joy1_i, joy2_i);
                count_q <= '0;
            end else if (clk_rise) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b1};
                if (count_q != CNT_MAX) begin
                    count_q <= count_q + 5'd1;
                end
                if (count_q == CNT_MAX - 5'd1) begin
                    frame_q <= 1'b1;
                end
            end
            tmo_q <= tmo_d;
            if (load_fall) begin
                link_q <= 1'b1;
            end else if (tmo_d == TMO_MAX) begin
                link_q <= 1'b0;
            end
        end
    end

    assign joy_data_o    = shreg_q[FRAME_BITS-1];
    assign shift_count_o = count_q;
    assign frame_o       = frame_q;
    assign link_active_o = link_q;

endmodule

// File: tb/tb_joyencoder_neptuno.sv
// Directed-vector bench for the NeptUNO joystick encoder: frame order, saturation,
// abort, load/clock coincidence, asynchronous reset and link watchdog.
module tb_joyencoder_neptuno;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       joy_clk_i = 1'b0;
    logic       joy_load_i = 1'b1;
    logic       joy_data_o;
    logic [7:0] joy1_i = 8'hFF;
    logic [7:0] joy2_i = 8'hFF;
    logic [4:0] shift_count_o;
    logic       frame_o;
    logic       link_active_o;

    int vectors = 0;
    int miscompares = 0;
    int frame_pulses = 0;

    always #5 clk_i = ~clk_i;

    joyencoder_neptuno #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .joy_clk_i     (joy_clk_i),
        .joy_load_i    (joy_load_i),
        .joy_data_o    (joy_data_o),
        .joy1_i        (joy1_i),
        .joy2_i        (joy2_i),
        .shift_count_o (shift_count_o),
        .frame_o       (frame_o),
        .link_active_o (link_active_o)
    );

    always @(negedge clk_i) if (frame_o) frame_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_pulse();
        joy_load_i = 1'b0;
        wait_cyc(16);
        joy_load_i = 1'b1;
        wait_cyc(8);
    endtask

    task automatic clk_edge();
        joy_clk_i = 1'b1;
        wait_cyc(8);
        joy_clk_i = 1'b0;
        wait_cyc(8);
    endtask

    initial begin
        logic [15:0] exp_stream;
        int base;
        int n;
        int hi_cyc;

        // 1: reset with random inputs
        joy1_i = 8'($urandom);
        joy2_i = 8'($urandom);
        joy_clk_i = 1'($urandom);
        joy_load_i = 1'($urandom);
        wait_cyc(6);
        chk("rst_data", 32'(joy_data_o), 32'd1);
        chk("rst_count", 32'(shift_count_o), 32'd0);
        chk("rst_link", 32'(link_active_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);
        $display("reset vectors done");
        joy_clk_i = 1'b0;
        joy_load_i = 1'b1;
        wait_cyc(2);
        rst_i = 1'b0;
        wait_cyc(10);

        // 2: full frame
        joy1_i = 8'hFE;
        joy2_i = 8'h7F;
        exp_stream = 16'hFE7F;
        base = frame_pulses;
        load_pulse();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("frame_bit%0d", i), 32'(joy_data_o), 32'(exp_stream[15-i]));
            clk_edge();
        end
        chk("frame_count", 32'(shift_count_o), 32'd16);
        chk("frame_pulses", 32'(frame_pulses - base), 32'd1);
        $display("full frame done joy1=fe joy2=7f");

        // 3: extra shifts past the frame
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("extra_bit%0d", i), 32'(joy_data_o), 32'd1);
            clk_edge();
            chk($sformatf("extra_count%0d", i), 32'(shift_count_o), 32'd16);
        end
        chk("extra_pulses", 32'(frame_pulses - base), 32'd1);
        $display("saturation done");

        // 4: abort after 5 shifts with new player-1 state
        load_pulse();
        for (int i = 0; i < 5; i++) clk_edge();
        chk("abort_pre_count", 32'(shift_count_o), 32'd5);
        base = frame_pulses;
        joy1_i = 8'h7F;
        load_pulse();
        chk("abort_data", 32'(joy_data_o), 32'd0);
        chk("abort_count", 32'(shift_count_o), 32'd0);
        clk_edge();
        chk("abort_next", 32'(joy_data_o), 32'd1);
        chk("abort_next_cnt", 32'(shift_count_o), 32'd1);
        chk("abort_pulses", 32'(frame_pulses - base), 32'd0);
        $display("abort done");

        // 5: clock rise coincident with load release
        joy_load_i = 1'b0;
        wait_cyc(16);
        joy_load_i = 1'b1;
        joy_clk_i = 1'b1;
        wait_cyc(8);
        joy_clk_i = 1'b0;
        wait_cyc(8);
        chk("coin_data", 32'(joy_data_o), 32'd0);
        chk("coin_count", 32'(shift_count_o), 32'd0);
        clk_edge();
        chk("coin_next", 32'(joy_data_o), 32'd1);
        chk("coin_next_cnt", 32'(shift_count_o), 32'd1);
        $display("load/clock coincidence done");

        // asynchronous reset mid-frame, then a fresh frame
        clk_edge();
        #3 rst_i = 1'b1;
        #2;
        chk("mrst_data", 32'(joy_data_o), 32'd1);
        chk("mrst_count", 32'(shift_count_o), 32'd0);
        chk("mrst_link", 32'(link_active_o), 32'd0);
        wait_cyc(3);
        rst_i = 1'b0;
        wait_cyc(4);
        joy1_i = 8'h7F;
        load_pulse();
        chk("mrst_reload", 32'(joy_data_o), 32'd0);
        $display("mid-frame reset done");

        // 6: watchdog
        n = 0;
        while (link_active_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("tmo_idle_link", 32'(link_active_o), 32'd0);
        joy_load_i = 1'b0;
        n = 0;
        while (!link_active_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("tmo_rise", 32'(link_active_o), 32'd1);
        hi_cyc = 0;
        while (link_active_o && hi_cyc < 1000) begin
            @(negedge clk_i);
            hi_cyc++;
            if (hi_cyc == 10) joy_load_i = 1'b1;
        end
        chk("tmo_cycles", 32'(hi_cyc), 32'd100);
        load_pulse();
        chk("tmo_relink", 32'(link_active_o), 32'd1);
        $display("watchdog done high_cycles=%0d", hi_cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
